idex_stage: RTL and testbench

ID/EX pipeline register with load-use hazard control for the 5-stage MIPS pipeline. Captures the decode-stage operands produced by the register file (`data1`/`data2`), the sign-extended immediate, register specifiers and control bits, and presents them to EX one cycle later. Detects load-use hazards against the instruction currently in EX, stalls IF/ID and the PC for a programmable number of cycles, and inserts bubbles. Supports a branch flush and keeps saturating stall and flush statistics.

---
 rtl/idex_stage.sv | 132 +++++++++++++
 tb/tb_idex_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline. It detects load-use
// hazards, stalls IF/ID for LUSE_STALL cycles, handles the branch flush and keeps event counters.
module idex_stage #(
  parameter int unsigned LUSE_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_data1,
  input  logic [31:0] id_data2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_branch,
  input  logic [3:0]  id_aluop,
  input  logic        flush_ex,
  output logic        ex_valid,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic        ex_alusrc,
  output logic        ex_regdst,
  output logic        ex_branch,
  output logic [3:0]  ex_aluop,
  output logic        stall_id,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0] STALL_INIT = 4'(LUSE_STALL - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       hazard;

  // Hazard is only raised from RUN; during STALL the counter alone decides.
  assign hazard = (state == RUN) & id_valid & ex_valid & ex_memread & (ex_rt != 5'd0) &
                  ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

  assign stall_id = (hazard | (state == STALL)) & ~flush_ex;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; rst is in the sensitivity list so it clears asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= 4'd0;
      stall_cnt   <= 16'd0;
      flush_cnt   <= 16'd0;
      ex_valid    <= 1'b0;
      ex_pc4      <= 32'd0;
      ex_data1    <= 32'd0;
      ex_data2    <= 32'd0;
      ex_imm      <= 32'd0;
      ex_rs       <= 5'd0;
      ex_rt       <= 5'd0;
      ex_rd       <= 5'd0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regdst   <= 1'b0;
      ex_branch   <= 1'b0;
      ex_aluop    <= 4'd0;
    end else if (flush_ex) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      state       <= RUN;
      cnt         <= 4'd0;
      if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end else if (stall_id) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_branch   <= 1'b0;
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (state == RUN) begin
        // The hazard cycle itself is the first bubble of the LUSE_STALL total.
        if (LUSE_STALL > 1) begin
          state <= STALL;
          cnt   <= STALL_INIT;
        end
      end else begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= RUN;
      end
    end else begin
      ex_valid    <= id_valid;
      ex_pc4      <= id_pc4;
      ex_data1    <= id_data1;
      ex_data2    <= id_data2;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_memtoreg <= id_memtoreg;
      ex_alusrc   <= id_alusrc;
      ex_regdst   <= id_regdst;
      ex_branch   <= id_branch;
      ex_aluop    <= id_aluop;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: three instances (LUSE_STALL = 1, 3, 15) share
// stimulus; expected EX contents are queued when driven and compared after the edge.
module tb_idex_stage;

  logic        clk, rst;
  logic        id_valid;
  logic [31:0] id_pc4, id_data1, id_data2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_alusrc, id_regdst, id_branch;
  logic [3:0]  id_aluop;
  logic        flush_ex;

  logic        ex_valid [3];
  logic [31:0] ex_pc4 [3], ex_data1 [3], ex_data2 [3], ex_imm [3];
  logic [4:0]  ex_rs [3], ex_rt [3], ex_rd [3];
  logic        ex_regwrite [3], ex_memread [3], ex_memwrite [3], ex_memtoreg [3];
  logic        ex_alusrc [3], ex_regdst [3], ex_branch [3];
  logic [3:0]  ex_aluop [3];
  logic        stall_id [3];
  logic [15:0] stall_cnt [3], flush_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    idex_stage #(.LUSE_STALL(g == 0 ? 1 : (g == 1 ? 3 : 15))) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc4(id_pc4), .id_data1(id_data1), .id_data2(id_data2),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
      .id_memtoreg(id_memtoreg), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
      .id_branch(id_branch), .id_aluop(id_aluop), .flush_ex(flush_ex),
      .ex_valid(ex_valid[g]), .ex_pc4(ex_pc4[g]), .ex_data1(ex_data1[g]),
      .ex_data2(ex_data2[g]), .ex_imm(ex_imm[g]), .ex_rs(ex_rs[g]), .ex_rt(ex_rt[g]),
      .ex_rd(ex_rd[g]), .ex_regwrite(ex_regwrite[g]), .ex_memread(ex_memread[g]),
      .ex_memwrite(ex_memwrite[g]), .ex_memtoreg(ex_memtoreg[g]), .ex_alusrc(ex_alusrc[g]),
      .ex_regdst(ex_regdst[g]), .ex_branch(ex_branch[g]), .ex_aluop(ex_aluop[g]),
      .stall_id(stall_id[g]), .stall_cnt(stall_cnt[g]), .flush_cnt(flush_cnt[g])
    );
  end

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic [31:0] data1;
    logic [4:0]  rd;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_s = 16'd0;
  logic [15:0] exp_f = 16'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic rw, input logic mr,
                      input logic [31:0] d1, input logic [4:0] rd);
    exp_t e;
    e.valid = v; e.regwrite = rw; e.memread = mr; e.data1 = d1; e.rd = rd;
    e.scnt = exp_s; e.fcnt = exp_f;
    sb.push_back(e);
  endtask

  // Advance one edge, then compare the oldest queued expectation against instance d.
  task automatic tick(input string tag, input int d);
    exp_t e;
    @(posedge clk); #1;
    check({tag, ".queued"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".valid"},    ex_valid[d],    e.valid);
      check({tag, ".regwrite"}, ex_regwrite[d], e.regwrite);
      check({tag, ".memread"},  ex_memread[d],  e.memread);
      check({tag, ".data1"},    ex_data1[d],    e.data1);
      check({tag, ".rd"},       ex_rd[d],       e.rd);
      check({tag, ".stall_cnt"}, stall_cnt[d],  e.scnt);
      check({tag, ".flush_cnt"}, flush_cnt[d],  e.fcnt);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic urs, input logic urt,
                     input logic rw, input logic mr, input logic [31:0] d1);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_uses_rs = urs; id_uses_rt = urt;
    id_regwrite = rw; id_memread = mr; id_memwrite = 1'b0; id_memtoreg = mr;
    id_alusrc = mr; id_regdst = ~mr; id_branch = 1'b0; id_aluop = v ? 4'h2 : 4'h0;
    id_data1 = d1; id_data2 = ~d1; id_pc4 = d1 + 32'd4; id_imm = {27'd0, rd};
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    flush_ex = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    exp_s = 16'd0;
    exp_f = 16'd0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    rst = 1'b0;
    check("rst.ex_valid",  ex_valid[0],  1'b0);
    check("rst.ex_data1",  ex_data1[0],  32'd0);
    check("rst.stall_cnt", stall_cnt[0], 16'd0);
    check("rst.stall_id",  stall_id[0],  1'b0);
    @(posedge clk); #1;

    // ---------------- LUSE_STALL = 1 (instance 0) ----------------
    drv(1, 5'd1, 5'd2, 5'd9, 1, 1, 1, 0, 32'h1234_5678);
    id_imm = 32'hFFFF_FFFC;
    push(1, 1, 0, 32'h1234_5678, 5'd9);
    tick("pass", 0);
    check("pass.imm", ex_imm[0], 32'hFFFF_FFFC);

    drv(1, 5'd3, 5'd8, 5'd0, 1, 0, 1, 1, 32'hA0A0_0001);
    check("l1.lw_nostall", stall_id[0], 1'b0);
    push(1, 1, 1, 32'hA0A0_0001, 5'd0);
    tick("l1.lw", 0);
    drv(1, 5'd8, 5'd4, 5'd10, 1, 1, 1, 0, 32'hB0B0_0002);
    #1 check("l1.stall", stall_id[0], 1'b1);
    exp_s++;
    push(0, 0, 0, 32'hA0A0_0001, 5'd0);
    tick("l1.bubble", 0);
    check("l1.release", stall_id[0], 1'b0);
    push(1, 1, 0, 32'hB0B0_0002, 5'd10);
    tick("l1.add", 0);

    // Asynchronous reset between edges with live EX contents.
    #3 rst = 1'b1;
    #1;
    check("arst.ex_valid",  ex_valid[0],  1'b0);
    check("arst.ex_data1",  ex_data1[0],  32'd0);
    check("arst.stall_cnt", stall_cnt[0], 16'd0);
    check("arst.stall_id",  stall_id[0],  1'b0);
    #1 rst = 1'b0;
    exp_s = 16'd0;
    idle();
    @(posedge clk); #1;

    drv(1, 5'd0, 5'd0, 5'd0, 1, 0, 1, 1, 32'hC0C0_0003);
    push(1, 1, 1, 32'hC0C0_0003, 5'd0);
    tick("r0.lw", 0);
    drv(1, 5'd0, 5'd0, 5'd11, 1, 1, 1, 0, 32'hD0D0_0004);
    #1 check("r0.nostall", stall_id[0], 1'b0);
    push(1, 1, 0, 32'hD0D0_0004, 5'd11);
    tick("r0.add", 0);

    drv(1, 5'd3, 5'd8, 5'd0, 1, 0, 1, 1, 32'hE0E0_0005);
    push(1, 1, 1, 32'hE0E0_0005, 5'd0);
    tick("nort.lw", 0);
    drv(1, 5'd5, 5'd8, 5'd12, 1, 0, 1, 0, 32'hF0F0_0006);
    #1 check("nort.nostall", stall_id[0], 1'b0);
    push(1, 1, 0, 32'hF0F0_0006, 5'd12);
    tick("nort.add", 0);

    drv(1, 5'd3, 5'd9, 5'd0, 1, 0, 1, 1, 32'h1111_0007);
    push(1, 1, 1, 32'h1111_0007, 5'd0);
    tick("rt.lw", 0);
    drv(1, 5'd2, 5'd9, 5'd14, 0, 1, 1, 0, 32'h2222_0008);
    #1 check("rt.stall", stall_id[0], 1'b1);
    exp_s++;
    push(0, 0, 0, 32'h1111_0007, 5'd0);
    tick("rt.bubble", 0);
    push(1, 1, 0, 32'h2222_0008, 5'd14);
    tick("rt.add", 0);

    drv(1, 5'd3, 5'd8, 5'd0, 1, 0, 1, 1, 32'h3333_0009);
    push(1, 1, 1, 32'h3333_0009, 5'd0);
    tick("fl.lw", 0);
    drv(1, 5'd8, 5'd4, 5'd13, 1, 1, 1, 0, 32'h4444_000A);
    flush_ex = 1'b1;
    #1 check("fl.stall_id", stall_id[0], 1'b0);
    exp_f++;
    push(0, 0, 0, 32'h3333_0009, 5'd0);
    tick("fl.bubble", 0);
    flush_ex = 1'b0;
    push(1, 1, 0, 32'h4444_000A, 5'd13);
    tick("fl.add", 0);

    drv(0, 5'd0, 5'd0, 5'd15, 0, 0, 0, 0, 32'h5555_000B);
    push(0, 0, 0, 32'h5555_000B, 5'd15);
    tick("inval", 0);

    // ---------------- LUSE_STALL = 3 (instance 1) ----------------
    do_reset();
    drv(1, 5'd3, 5'd8, 5'd0, 1, 0, 1, 1, 32'hA3A3_0001);
    push(1, 1, 1, 32'hA3A3_0001, 5'd0);
    tick("s3.lw", 1);
    drv(1, 5'd8, 5'd4, 5'd10, 1, 1, 1, 0, 32'hB3B3_0002);
    for (int k = 0; k < 3; k++) begin
      #1 check("s3.stall", stall_id[1], 1'b1);
      exp_s++;
      push(0, 0, 0, 32'hA3A3_0001, 5'd0);
      tick("s3.bubble", 1);
    end
    check("s3.release", stall_id[1], 1'b0);
    push(1, 1, 0, 32'hB3B3_0002, 5'd10);
    tick("s3.add", 1);

    drv(1, 5'd3, 5'd9, 5'd0, 1, 0, 1, 1, 32'hC3C3_0003);
    push(1, 1, 1, 32'hC3C3_0003, 5'd0);
    tick("s3rt.lw", 1);
    drv(1, 5'd2, 5'd9, 5'd14, 0, 1, 1, 0, 32'hD3D3_0004);
    for (int k = 0; k < 3; k++) begin
      #1 check("s3rt.stall", stall_id[1], 1'b1);
      exp_s++;
      push(0, 0, 0, 32'hC3C3_0003, 5'd0);
      tick("s3rt.bubble", 1);
    end
    check("s3rt.release", stall_id[1], 1'b0);
    push(1, 1, 0, 32'hD3D3_0004, 5'd14);
    tick("s3rt.add", 1);

    // Flush in the second stall cycle aborts the stall.
    drv(1, 5'd3, 5'd8, 5'd0, 1, 0, 1, 1, 32'hE3E3_0005);
    push(1, 1, 1, 32'hE3E3_0005, 5'd0);
    tick("s3fl.lw", 1);
    drv(1, 5'd8, 5'd4, 5'd11, 1, 1, 1, 0, 32'hF3F3_0006);
    #1 check("s3fl.stall1", stall_id[1], 1'b1);
    exp_s++;
    push(0, 0, 0, 32'hE3E3_0005, 5'd0);
    tick("s3fl.bubble1", 1);
    flush_ex = 1'b1;
    #1 check("s3fl.stall2", stall_id[1], 1'b0);
    exp_f++;
    push(0, 0, 0, 32'hE3E3_0005, 5'd0);
    tick("s3fl.flush", 1);
    flush_ex = 1'b0;
    #1 check("s3fl.run", stall_id[1], 1'b0);
    push(1, 1, 0, 32'hF3F3_0006, 5'd11);
    tick("s3fl.add", 1);

    // Reset mid-stall: back in RUN, no further bubbles.
    drv(1, 5'd3, 5'd8, 5'd0, 1, 0, 1, 1, 32'h1313_0007);
    push(1, 1, 1, 32'h1313_0007, 5'd0);
    tick("s3rst.lw", 1);
    drv(1, 5'd8, 5'd4, 5'd12, 1, 1, 1, 0, 32'h2323_0008);
    exp_s++;
    push(0, 0, 0, 32'h1313_0007, 5'd0);
    tick("s3rst.bubble", 1);
    check("s3rst.in_stall", stall_id[1], 1'b1);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    exp_s = 16'd0;
    exp_f = 16'd0;
    #1 check("s3rst.stall_id", stall_id[1], 1'b0);
    push(1, 1, 0, 32'h2323_0008, 5'd12);
    tick("s3rst.add", 1);

    // ---------------- Saturation, LUSE_STALL = 15 (instance 2) ----------------
    do_reset();
    drv(1, 5'd8, 5'd8, 5'd0, 1, 0, 1, 1, 32'h5A5A_5A5A);
    repeat (16) @(posedge clk);
    #1 check("sat.first_run", stall_cnt[2], 16'd15);
    repeat (70000) @(posedge clk);
    #1;
    check("sat.stall_cnt", stall_cnt[2], 16'hFFFF);
    check("sat.flush_cnt", flush_cnt[2], 16'd0);
    check("sat.sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
